// File: rtl/keypad_matrix_scanner_pkg.sv
// Shared types, constants and bit-map helpers for the 4x4 keypad matrix scanner.
package keypad_matrix_scanner_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESSED  = 2'd2,
      RELEASE  = 2'd3
   } state_e;

   localparam int          NUM_ROWS = 4;
   localparam int          NUM_COLS = 4;
   localparam logic [15:0] KEY_NONE = 16'h0000;
   localparam logic [3:0]  ROW_INIT = 4'b1110;

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] n;
      n = 5'd0;
      for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
      return n;
   endfunction

   // Index of the highest set bit; only meaningful when exactly one bit is set.
   function automatic logic [3:0] onehot_index(input logic [15:0] v);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = 0; i < 16; i++) if (v[i]) idx = i[3:0];
      return idx;
   endfunction

endpackage

// File: rtl/keypad_matrix_scanner_if.sv
// Keypad pin and decoded key-code bundle between the scanner and its neighbours.
interface keypad_matrix_scanner_if;
   logic [3:0]  col_in;
   logic [3:0]  row_out;
   logic [15:0] onehot;
   logic [3:0]  key_code;
   logic        key_valid;

   modport master (
      input  col_in,
      output row_out,
      output onehot,
      output key_code,
      output key_valid
   );

   modport slave (
      output col_in,
      input  row_out,
      input  onehot,
      input  key_code,
      input  key_valid
   );
endinterface

// File: rtl/keypad_matrix_scanner_col_sync.sv
// Two-flop synchroniser for the asynchronous keypad column inputs (idle level = all ones).
module keypad_matrix_scanner_col_sync (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] i_col,
   output logic [3:0] o_col
);

   logic [3:0] r_meta;
   logic [3:0] r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 4'b1111;
         r_sync <= 4'b1111;
      end else begin
         r_meta <= i_col;
         r_sync <= r_meta;
      end
   end

   assign o_col = r_sync;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad scanner: row strobing, per-frame key map, debounce FSM and multi-key rejection.
module keypad_matrix_scanner
   import keypad_matrix_scanner_pkg::*;
#(
   parameter int SCAN_DIV        = 50000,
   parameter int DEBOUNCE_FRAMES = 20
) (
   input logic                     clk,
   input logic                     rst_n,
   keypad_matrix_scanner_if.master kp
);

   localparam int             DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int             CW         = $clog2(DEBOUNCE_FRAMES + 1);
   localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0]  CNT_TARGET = CW'(DEBOUNCE_FRAMES);
   localparam logic [CW-1:0]  CNT_MAX    = '1;

   logic [NUM_COLS-1:0] w_col_sync;
   logic [DW-1:0]       r_dwell;
   logic [3:0]          r_row;
   logic [1:0]          r_row_idx;
   logic [15:0]         r_raw;
   logic                w_tick;
   logic                w_frame_end;
   logic [15:0]         w_row_bits;
   logic [15:0]         w_frame;
   logic                w_single;
   logic [3:0]          w_index;

   state_e              r_state, w_state_nxt;
   logic [15:0]         r_cand, w_cand_nxt;
   logic [CW-1:0]       r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [15:0]         r_onehot, w_onehot_nxt;
   logic [3:0]          r_key_code, w_code_nxt;
   logic                r_key_valid, w_valid_nxt;

   keypad_matrix_scanner_col_sync u_col_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_col (kp.col_in),
      .o_col (w_col_sync)
   );

   assign w_tick      = (r_dwell == DWELL_LAST);
   assign w_frame_end = w_tick && (r_row_idx == 2'(NUM_ROWS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dwell   <= '0;
         r_row     <= ROW_INIT;
         r_row_idx <= 2'd0;
      end else if (w_tick) begin
         r_dwell   <= '0;
         r_row     <= {r_row[2:0], r_row[3]};
         r_row_idx <= r_row_idx + 2'd1;
      end else begin
         r_dwell   <= r_dwell + 1'b1;
      end
   end

   // Columns are active-low; the frame seen at frame_end already includes the last row.
   assign w_row_bits = {12'b0, ~w_col_sync} << {r_row_idx, 2'b00};
   assign w_frame    = r_raw | w_row_bits;
   assign w_single   = (popcount16(w_frame) == 5'd1);
   assign w_index    = onehot_index(w_frame);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           r_raw <= KEY_NONE;
      else if (w_frame_end) r_raw <= KEY_NONE;
      else if (w_tick)      r_raw <= w_frame;
   end

   assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

   always_comb begin
      w_state_nxt  = r_state;
      w_cand_nxt   = r_cand;
      w_cnt_nxt    = r_cnt;
      w_onehot_nxt = r_onehot;
      w_code_nxt   = r_key_code;
      w_valid_nxt  = 1'b0;
      if (w_frame_end) begin
         case (r_state)
            IDLE: begin
               if (w_single) begin
                  w_state_nxt = DEBOUNCE;
                  w_cand_nxt  = w_frame;
                  w_cnt_nxt   = CW'(1);
               end
            end
            DEBOUNCE: begin
               if (w_frame == r_cand) begin
                  w_cnt_nxt = w_cnt_inc;
                  if (w_cnt_inc >= CNT_TARGET) begin
                     w_state_nxt  = PRESSED;
                     w_onehot_nxt = r_cand;
                     w_code_nxt   = w_index;
                     w_valid_nxt  = 1'b1;
                     w_cnt_nxt    = '0;
                  end
               end else begin
                  w_state_nxt = IDLE;
                  w_cnt_nxt   = '0;
               end
            end
            PRESSED: begin
               // Extra keys on top of the held one are deliberately ignored.
               if (w_frame == KEY_NONE) begin
                  w_state_nxt = RELEASE;
                  w_cnt_nxt   = CW'(1);
               end
            end
            RELEASE: begin
               if (w_frame == KEY_NONE) begin
                  w_cnt_nxt = w_cnt_inc;
                  if (w_cnt_inc >= CNT_TARGET) begin
                     w_state_nxt  = IDLE;
                     w_onehot_nxt = KEY_NONE;
                     w_cnt_nxt    = '0;
                  end
               end else begin
                  w_state_nxt = PRESSED;
                  w_cnt_nxt   = '0;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cand      <= KEY_NONE;
         r_cnt       <= '0;
         r_onehot    <= KEY_NONE;
         r_key_code  <= 4'd0;
         r_key_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cand      <= w_cand_nxt;
         r_cnt       <= w_cnt_nxt;
         r_onehot    <= w_onehot_nxt;
         r_key_code  <= w_code_nxt;
         r_key_valid <= w_valid_nxt;
      end
   end

   assign kp.row_out   = r_row;
   assign kp.onehot    = r_onehot;
   assign kp.key_code  = r_key_code;
   assign kp.key_valid = r_key_valid;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner with a resistive-free 4x4 keypad model.
module tb_keypad_matrix_scanner;

   logic        clk;
   logic        rst_n;
   logic [15:0] keys;
   int          n_cmp;
   int          n_err;
   int          n_pulse;

   keypad_matrix_scanner_if kp ();

   keypad_matrix_scanner #(
      .SCAN_DIV        (4),
      .DEBOUNCE_FRAMES (3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .kp    (kp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A held key pulls its column low while its row is driven low.
   always_comb begin
      kp.col_in = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!kp.row_out[r] && keys[r*4+c]) kp.col_in[c] = 1'b0;
   end

   always @(posedge clk) if (kp.key_valid === 1'b1) n_pulse++;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic next_frame();
      logic [3:0] prev_row;
      bit         found;
      found    = 1'b0;
      prev_row = kp.row_out;
      for (int i = 0; i < 64 && !found; i++) begin
         @(negedge clk);
         if (prev_row == 4'b0111 && kp.row_out == 4'b1110) found = 1'b1;
         prev_row = kp.row_out;
      end
      n_cmp++;
      assert (found)
      else begin
         n_err++;
         $error("FAIL frame_timeout: observed no frame start expected one within 64 clk");
      end
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) next_frame();
   endtask

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      n_pulse = 0;
      keys    = 16'h0000;
      rst_n   = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_row",    16'(kp.row_out),   16'h000e);
      check("rst_onehot", kp.onehot,         16'h0000);
      check("rst_code",   16'(kp.key_code),  16'h0000);
      check("rst_valid",  16'(kp.key_valid), 16'h0000);
      rst_n = 1'b1;

      // Clean press of row 2 / col 1
      next_frame();
      keys = 16'h0200;
      frames(2);
      check("press_f2_onehot", kp.onehot, 16'h0000);
      check("press_f2_valid",  16'(kp.key_valid), 16'h0000);
      next_frame();
      check("press_onehot", kp.onehot,         16'h0200);
      check("press_code",   16'(kp.key_code),  16'h0009);
      check("press_valid",  16'(kp.key_valid), 16'h0001);
      @(negedge clk);
      check("press_valid_fall", 16'(kp.key_valid), 16'h0000);
      next_frame();
      keys = 16'h0000;
      frames(2);
      check("rel_f2_onehot", kp.onehot, 16'h0200);
      next_frame();
      check("rel_onehot",    kp.onehot,        16'h0000);
      check("rel_code_hold", 16'(kp.key_code), 16'h0009);
      check("rel_pulses",    16'(n_pulse),     16'h0001);

      // Bounce: closed 2, open 1, closed 2, open
      keys = 16'h0040;
      frames(2);
      keys = 16'h0000;
      next_frame();
      check("bounce_gap", kp.onehot, 16'h0000);
      keys = 16'h0040;
      frames(2);
      check("bounce_c2", kp.onehot, 16'h0000);
      keys = 16'h0000;
      frames(2);
      check("bounce_end",    kp.onehot,    16'h0000);
      check("bounce_pulses", 16'(n_pulse), 16'h0001);

      // Two keys together
      keys = 16'h0021;
      frames(5);
      check("two_f5", kp.onehot, 16'h0000);
      frames(5);
      check("two_f10",    kp.onehot,    16'h0000);
      check("two_pulses", 16'(n_pulse), 16'h0001);
      keys = 16'h0000;
      next_frame();

      // Release with a glitch on release frame 2
      keys = 16'h0020;
      frames(3);
      check("k5_onehot", kp.onehot,        16'h0020);
      check("k5_code",   16'(kp.key_code), 16'h0005);
      keys = 16'h0000;
      next_frame();
      keys = 16'h0020;
      next_frame();
      check("glitch_hold", kp.onehot, 16'h0020);
      keys = 16'h0000;
      frames(2);
      check("glitch_z2", kp.onehot, 16'h0020);
      next_frame();
      check("glitch_z3",     kp.onehot,    16'h0000);
      check("glitch_pulses", 16'(n_pulse), 16'h0002);

      // Second key while one is held
      keys = 16'h0020;
      frames(3);
      check("hold5_onehot", kp.onehot, 16'h0020);
      keys = 16'h1020;
      frames(5);
      check("extra_onehot", kp.onehot,        16'h0020);
      check("extra_code",   16'(kp.key_code), 16'h0005);
      check("extra_pulses", 16'(n_pulse),     16'h0003);
      keys = 16'h0000;
      frames(3);
      check("both_rel", kp.onehot, 16'h0000);
      keys = 16'h1000;
      frames(3);
      check("k12_onehot", kp.onehot,         16'h1000);
      check("k12_code",   16'(kp.key_code),  16'h000c);
      check("k12_valid",  16'(kp.key_valid), 16'h0001);
      repeat (5) @(negedge clk);
      check("k12_pulses", 16'(n_pulse),      16'h0004);
      check("mid_row",    16'(kp.row_out),   16'h000d);

      // Asynchronous reset while PRESSED
      #2 rst_n = 1'b0;
      #1;
      check("arst_row",    16'(kp.row_out),   16'h000e);
      check("arst_onehot", kp.onehot,         16'h0000);
      check("arst_code",   16'(kp.key_code),  16'h0000);
      check("arst_valid",  16'(kp.key_valid), 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
